bitmask_scheduler: RTL and testbench
====================================

BITMASK_SCHEDULER -- requirements
Module: bitmask_scheduler

Interface
REQ-001 Parameter NUM_LANE, default 8, SHALL set the number of parallel 7-bit lanes sequenced in lockstep.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous abort; discards the current group.
REQ-005 in_valid  input  1  group mask offered.
REQ-006 in_ready  output  1  scheduler accepts a group this cycle.
REQ-007 in_mask  input  NUM_LANE*7  per-lane bitmask; lane k occupies bits [7k+6:7k].
REQ-008 out_valid  output  1  a beat is presented.
REQ-009 out_ready  input  1  downstream consumes the beat.
REQ-010 out_lane_val  output  NUM_LANE  lane k has a bit position this beat.
REQ-011 out_lane_idx  output  NUM_LANE*3  bit position for lane k at [3k+2:3k], range 0..6.
REQ-012 out_first  output  1  beat is the first of its group.
REQ-013 out_last  output  1  beat is the last of its group.
REQ-014 busy  output  1  a group is held (state RUN).

Function
REQ-015 The block SHALL hold a registered copy of each lane mask and two states: IDLE and RUN.
REQ-016 Per lane, out_lane_idx SHALL be the index of the highest set bit of the held mask (bit 6 highest priority); out_lane_val SHALL be 1 iff the held mask is non-zero.
REQ-017 Lanes with an all-zero held mask SHALL drive out_lane_idx = 3'b000.
REQ-018 in_ready SHALL be 1 in IDLE, and in RUN only when out_valid && out_ready && out_last (back-to-back load); it SHALL be 0 whenever clear is 1.
REQ-019 A load (in_valid && in_ready) SHALL capture in_mask, set out_first, and enter RUN; out_valid SHALL rise the cycle after the load.
REQ-020 out_valid SHALL equal (state == RUN); no combinational path from in_* to out_*.
REQ-021 On out_valid && out_ready, each lane SHALL clear the bit currently reported and out_first SHALL drop to 0.
REQ-022 out_last SHALL be 1 iff every lane mask is zero after clearing the reported bits.
REQ-023 A group SHALL take max(popcount over lanes) beats, minimum 1; an all-zero group SHALL produce exactly one beat with out_lane_val = 0, out_first = out_last = 1.
REQ-024 On out_valid && !out_ready, all outputs and held masks SHALL remain stable until consumed.
REQ-025 On the last beat consumed with no load, the state SHALL return to IDLE; with a simultaneous load, the state SHALL stay in RUN with the new group and out_first = 1.
REQ-026 clear SHALL take priority over load and consumption: the next state SHALL be IDLE, masks zeroed, out_first 0.
REQ-027 Reported indices SHALL be strictly decreasing within a lane across one group.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, masks 0, out_first 0, out_valid 0, busy 0, out_lane_val 0, out_lane_idx 0, out_last 0, and in_ready 1 (when clear = 0), independent of clk.
REQ-029 Reset asserted mid-group SHALL discard the group; no beat of it SHALL appear after deassertion.

Verification (NUM_LANE = 2)
REQ-030 Load lane0 = 7'b1010010, lane1 = 7'b0000001, out_ready = 1 -> three beats: (val 11, idx0 6, idx1 0, first), (val 01, idx0 4), (val 01, idx0 1, last); then IDLE.
REQ-031 Load both lanes 7'b0000000 -> one beat, out_lane_val = 00, out_first = out_last = 1.
REQ-032 Lane0 = 7'b1111111, out_ready held low 5 cycles after the first beat -> outputs frozen at idx 6 for 5 cycles; 7 beats total, idx 6..0.
REQ-033 Last beat consumed with in_valid = 1 and new mask 7'b0100000 on lane0 -> next cycle out_valid = 1, out_first = 1, idx0 = 5, no idle bubble.
REQ-034 clear on the second beat of a 4-beat group -> next cycle out_valid = 0, busy = 0, in_ready = 1; the remaining beats never appear.
REQ-035 Asynchronous reset pulse between clock edges mid-group -> out_valid = 0 and busy = 0 before the next rising edge; the subsequent load behaves as in REQ-030.

Source files
------------

// File: rtl/bitmask_scheduler.sv
// rtl/bitmask_scheduler.sv - per-lane highest-set-bit sequencer over a held group of lane masks
module bitmask_scheduler #(
    parameter int NUM_LANE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_LANE*7-1:0] in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_LANE-1:0]   out_lane_val,
    output logic [NUM_LANE*3-1:0] out_lane_idx,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_LANE*7-1:0] r_mask;
    logic                  r_first;

    logic [NUM_LANE*7-1:0] w_next_mask;
    logic [NUM_LANE-1:0]   w_val;
    logic [NUM_LANE*3-1:0] w_idx;
    logic                  w_last;
    logic                  w_load;
    logic                  w_consume;

    // Highest set bit per lane wins; its one-hot is stripped to form the post-beat mask.
    always_comb begin
        logic [6:0] v_lane;
        logic [6:0] v_hot;
        w_val       = '0;
        w_idx       = '0;
        w_next_mask = '0;
        for (int k = 0; k < NUM_LANE; k++) begin
            v_lane = r_mask[7*k +: 7];
            v_hot  = '0;
            for (int j = 0; j < 7; j++) begin
                if (v_lane[j]) begin
                    w_val[k]          = 1'b1;
                    w_idx[3*k +: 3]   = 3'(j);
                    v_hot             = 7'(1 << j);
                end
            end
            w_next_mask[7*k +: 7] = v_lane & ~v_hot;
        end
    end

    assign w_last    = (r_state == S_RUN) && (w_next_mask == '0);
    assign w_consume = (r_state == S_RUN) && out_ready;
    assign in_ready  = !clear && ((r_state == S_IDLE) || (out_ready && w_last));
    assign w_load    = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_first <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_first <= 1'b0;
        end else if (w_load) begin
            r_state <= S_RUN;
            r_mask  <= in_mask;
            r_first <= 1'b1;
        end else if (w_consume) begin
            r_mask  <= w_next_mask;
            r_first <= 1'b0;
            if (w_last) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign out_valid    = (r_state == S_RUN);
    assign busy         = (r_state == S_RUN);
    assign out_lane_val = w_val;
    assign out_lane_idx = w_idx;
    assign out_first    = r_first;
    assign out_last     = w_last;

endmodule

// File: tb/tb_bitmask_scheduler.sv
// tb/tb_bitmask_scheduler.sv - randomized and directed self-checking bench for bitmask_scheduler
module tb_bitmask_scheduler;

    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [NL*7-1:0] in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [NL-1:0] out_lane_val;
    logic [NL*3-1:0] out_lane_idx;
    logic          out_first;
    logic          out_last;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    bitmask_scheduler #(.NUM_LANE(NL)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_val (out_lane_val),
        .out_lane_idx (out_lane_idx),
        .out_first    (out_first),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: beat b of a lane reports the b-th set bit counted from the top.
    function automatic void exp_beat(input logic [NL*7-1:0] m, input int b,
                                     output logic [10:0] exp_v, output int nb);
        logic [NL-1:0]   val;
        logic [NL*3-1:0] idx;
        logic [6:0]      mm;
        int              c;
        nb  = 1;
        val = '0;
        idx = '0;
        for (int l = 0; l < NL; l++) begin
            mm = m[7*l +: 7];
            if ($countones(mm) > nb) nb = $countones(mm);
            c = 0;
            for (int j = 6; j >= 0; j--) begin
                if (mm[j]) begin
                    if (c == b) begin
                        val[l]          = 1'b1;
                        idx[3*l +: 3]   = 3'(j);
                    end
                    c++;
                end
            end
        end
        exp_v = {1'b1, val, idx, (b == 0), (b == nb - 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, busy, in_ready, out_lane_val, out_lane_idx, out_first, out_last} !== 13'b0010000000000)
            $display("FAIL reset_state: got %b want %b",
                     {out_valid, busy, in_ready, out_lane_val, out_lane_idx, out_first, out_last}, 13'b0010000000000);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_group(input logic [NL*7-1:0] m, input int stall_pct, input string name);
        logic [10:0] ev;
        logic [10:0] got;
        int nb, b, cyc;
        logic rdy;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL %s_idle_ready: got %b want 1", name, in_ready);
        else n_pass++;
        in_valid = 1'b1; in_mask = m; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_mask = 14'($urandom);
        exp_beat(m, 0, ev, nb);
        b = 0; cyc = 0;
        while (b < nb && cyc < 200) begin
            exp_beat(m, b, ev, nb);
            got = {out_valid, out_lane_val, out_lane_idx, out_first, out_last};
            n_total++;
            if (got !== ev) $display("FAIL %s_beat%0d: got %h want %h (mask %h)", name, b, got, ev, m);
            else n_pass++;
            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            tick();
            cyc++;
            if (rdy) b++;
        end
        out_ready = 1'b0;
        n_total++;
        if (cyc >= 200) $display("FAIL %s_timeout: got %0d cycles want <200", name, cyc);
        else if ({out_valid, busy, in_ready} !== 3'b001)
            $display("FAIL %s_return_idle: got %b want 001", name, {out_valid, busy, in_ready});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [10:0] exp_tab [3];
        exp_tab[0] = {1'b1, 2'b11, 6'b000110, 1'b1, 1'b0};
        exp_tab[1] = {1'b1, 2'b01, 6'b000100, 1'b0, 1'b0};
        exp_tab[2] = {1'b1, 2'b01, 6'b000001, 1'b0, 1'b1};
        in_valid = 1'b1; in_mask = {7'b0000001, 7'b1010010}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({out_valid, out_lane_val, out_lane_idx, out_first, out_last} !== exp_tab[i])
                $display("FAIL directed_beat%0d: got %b want %b", i,
                         {out_valid, out_lane_val, out_lane_idx, out_first, out_last}, exp_tab[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL directed_idle: got %b want 00", {out_valid, busy});
        else n_pass++;
        out_ready = 1'b0;
        check_group('0, 0, "all_zero");
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_mask = {7'b0000000, 7'b1111111}; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({out_valid, out_lane_val, out_lane_idx[2:0], out_first} !== 7'b1_01_110_1)
                $display("FAIL stall_hold%0d: got %b want 1011101", i,
                         {out_valid, out_lane_val, out_lane_idx[2:0], out_first});
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            n_total++;
            if ({out_valid, out_lane_idx[2:0], out_last} !== {1'b1, 3'(i), (i == 0)})
                $display("FAIL stall_seq_idx%0d: got %b want %b", i,
                         {out_valid, out_lane_idx[2:0], out_last}, {1'b1, 3'(i), (i == 0)});
            else n_pass++;
            tick();
        end
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL stall_end: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_mask = {7'b0, 7'b0000011}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_total++;
        if ({out_last, in_ready} !== 2'b11) $display("FAIL b2b_ready: got %b want 11", {out_last, in_ready});
        else n_pass++;
        in_valid = 1'b1; in_mask = {7'b0, 7'b0100000};
        tick();
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, out_lane_val, out_lane_idx, out_first, out_last} !== 11'b1_01_000101_1_1)
            $display("FAIL b2b_new_group: got %b want 10100010111",
                     {out_valid, out_lane_val, out_lane_idx, out_first, out_last});
        else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {out_valid, busy});
        else n_pass++;
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_mask = {7'b0, 7'b1111000}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1;
        #1;
        n_total++;
        if ({out_lane_idx[2:0], in_ready} !== 4'b1010) $display("FAIL clear_beat2: got %b want 1010", {out_lane_idx[2:0], in_ready});
        else n_pass++;
        tick();
        clear = 1'b0;
        #1;
        n_total++;
        if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL clear_abort: got %b want 001", {out_valid, busy, in_ready});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL clear_no_tail%0d: got %b want 0", i, out_valid);
            else n_pass++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_mask = {7'b0000001, 7'b1010010}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, busy, out_lane_val} !== 4'b0000) $display("FAIL async_reset: got %b want 0000", {out_valid, busy, out_lane_val});
        else n_pass++;
        #1 reset = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL async_no_tail: got %b want 0", out_valid);
        else n_pass++;
        out_ready = 1'b0;
        test_directed();
    endtask

    task automatic test_random();
        logic [NL*7-1:0] m;
        for (int g = 0; g < 25; g++) begin
            m = 14'($urandom);
            for (int l = 0; l < NL; l++)
                if ($urandom_range(3) == 0) m[7*l +: 7] = '0;
            check_group(m, 30, $sformatf("rand%0d", g));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
